accum_drain: RTL and testbench
==============================

// Module: accum_drain
// PURPOSE
//  Reader/drain engine for one accumulator column (accumCol). After a matmul pass it
//  reads rows 0..count-1 through the column's read port, streams them out on a
//  valid/ready interface (to host/activation stage), then optionally pulses the
//  column's clear. Sits between accumCol and the result/output path.
// PARAMETERS
//  DATA_W  8   accumulator word width (matches accumCol io_rd_data)
//  ADDR_W  4   accumulator address width
//  DEPTH   16  accumulator rows (2**ADDR_W)
// PORTS
//  clock            in   1         single clock, rising edge
//  reset            in   1         asynchronous, active-low reset
//  io_start         in   1         start drain; sampled only in IDLE
//  io_count         in   ADDR_W+1  rows to drain, sampled with io_start; >DEPTH clamps to DEPTH
//  io_clear_en      in   1         sampled with io_start; 1 = pulse clear after drain
//  io_busy          out  1         high in every state except IDLE
//  io_done          out  1         one-cycle pulse at end of drain
//  io_acc_rd_en     out  1         to accumCol io_rd_en
//  io_acc_rd_addr   out  ADDR_W    to accumCol io_rd_addr
//  io_acc_rd_data   in   DATA_W    from accumCol io_rd_data (combinational, same cycle)
//  io_acc_clear     out  1         to accumCol io_clear, one-cycle pulse
//  io_out_valid     out  1         output word valid
//  io_out_ready     in   1         downstream accepts when valid&ready
//  io_out_data      out  DATA_W    output word (registered)
//  io_out_last      out  1         marks final word of the drain
// BEHAVIOUR
//  - Reset (async, reset=0): state IDLE; rd addr counter, remaining count, out_data,
//    out_valid, out_last, io_done, io_acc_clear, io_busy all 0. Reset mid-drain aborts
//    immediately; no clear is issued; accumulator contents untouched.
//  - FSM: IDLE -> READ -> FLUSH -> CLEAR -> IDLE (CLEAR skipped when clear_en=0).
//  - IDLE: io_start=1 latches count (clamped), clear_en; addr<=0. count=0 -> go to
//    CLEAR (if clear_en) else straight back with io_done pulse next cycle; no reads.
//  - READ: load = (!out_valid | io_out_ready) & remaining>0. io_acc_rd_en = load,
//    io_acc_rd_addr = addr counter. On load: out_data<=io_acc_rd_data, out_valid<=1,
//    out_last<=(remaining==1), addr++, remaining--. Last load -> FLUSH.
//  - Output register holds data/last stable while valid & !ready (no drop, no dup).
//    Throughput 1 word/cycle with ready high; first valid 2 cycles after io_start.
//  - FLUSH: wait for handshake of word with out_last; then out_valid<=0 and go to
//    CLEAR (clear_en=1) or IDLE with io_done=1 in that next cycle.
//  - CLEAR: io_acc_clear=1 and io_done=1 for exactly one cycle, then IDLE.
//  - io_acc_rd_en and io_acc_clear never both high; neither high in IDLE.
//  - io_start while busy is ignored. io_count/io_clear_en changes after start ignored.
//  - Address counter wraps at DEPTH only via clamp; never exceeds DEPTH-1 when rd_en=1.
//  - Caller must hold accumCol writes off while io_busy=1; block does not check.
// TESTING
//  1 count=16, clear_en=1, ready=1, mem[i]=i+1 -> out 1..16 on cycles 2..17, last on
//    cycle 17 only, io_acc_clear+io_done at cycle 18, busy low at 19, mem all 0.
//  2 count=4, ready toggles 1,0,0,1,... -> data 1,2,3,4 in order, held stable during
//    stalls, rd_en only on load cycles, exactly 4 rd_en pulses.
//  3 count=0, clear_en=0 -> no rd_en, no out_valid, no clear, io_done 1 cycle later.
//  4 count=20 -> clamped: exactly 16 words, addrs 0..15, last on word 16.
//  5 io_start pulsed again mid-drain -> ignored; word count unchanged.
//  6 reset low during READ (word 5 pending, ready=0) -> all outputs 0 immediately,
//    no clear pulse; new start after release drains from addr 0 with original data.

Source files
------------

// File: rtl/accum_drain_if.sv
// Accumulator-column read port plus the drained-word output stream of accum_drain.
// The master modport is the drain engine; the slave side is accumCol plus the downstream consumer.
interface accum_drain_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              io_acc_rd_en;
  logic [ADDR_W-1:0] io_acc_rd_addr;
  logic [DATA_W-1:0] io_acc_rd_data;
  logic              io_acc_clear;
  logic              io_out_valid;
  logic              io_out_ready;
  logic [DATA_W-1:0] io_out_data;
  logic              io_out_last;

  modport master (
    output io_acc_rd_en, io_acc_rd_addr, io_acc_clear,
    output io_out_valid, io_out_data, io_out_last,
    input  io_acc_rd_data, io_out_ready
  );

  modport slave (
    input  io_acc_rd_en, io_acc_rd_addr, io_acc_clear,
    input  io_out_valid, io_out_data, io_out_last,
    output io_acc_rd_data, io_out_ready
  );
endinterface

// File: rtl/accum_drain.sv
// Drain engine for one accumulator column: reads rows 0..count-1 and streams them out on valid/ready.
// After the drain it can pulse the column clear.
module accum_drain #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_start,
  input  logic [ADDR_W:0]   io_count,
  input  logic              io_clear_en,
  output logic              io_busy,
  output logic              io_done,
  accum_drain_if.master     bus
);

  typedef enum logic [1:0] {IDLE, READ, FLUSH, CLEAR} state_e;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remaining_q;
  logic              clear_en_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              done_q;
  logic              clear_q;
  logic              busy_q;

  logic              load_d;
  logic              handshake_d;
  logic [ADDR_W:0]   count_d;

  function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] c);
    return (c > DEPTH_C) ? DEPTH_C : c;
  endfunction

  // A row is fetched whenever the output register is free or being emptied this cycle.
  always_comb begin
    count_d     = clamp_count(io_count);
    handshake_d = out_valid_q && bus.io_out_ready;
    load_d      = (state_q == READ) && (!out_valid_q || bus.io_out_ready) &&
                  (remaining_q != '0);
  end

  assign bus.io_acc_rd_en   = load_d;
  assign bus.io_acc_rd_addr = addr_q;
  assign bus.io_acc_clear   = clear_q;
  assign bus.io_out_valid   = out_valid_q;
  assign bus.io_out_data    = out_data_q;
  assign bus.io_out_last    = out_last_q;
  assign io_busy            = busy_q;
  assign io_done            = done_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      clear_en_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      clear_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      clear_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (io_start) begin
            addr_q      <= '0;
            remaining_q <= count_d;
            clear_en_q  <= io_clear_en;
            out_last_q  <= 1'b0;
            if (count_d != '0) begin
              state_q <= READ;
              busy_q  <= 1'b1;
            end else if (io_clear_en) begin
              state_q <= CLEAR;
              busy_q  <= 1'b1;
              clear_q <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              done_q  <= 1'b1;
            end
          end
        end

        READ: begin
          if (load_d) begin
            out_data_q  <= bus.io_acc_rd_data;
            out_valid_q <= 1'b1;
            out_last_q  <= (remaining_q == ONE_C);
            addr_q      <= addr_q + ADDR_W'(1);
            remaining_q <= remaining_q - ONE_C;
            if (remaining_q == ONE_C) begin
              state_q <= FLUSH;
            end
          end else if (handshake_d) begin
            out_valid_q <= 1'b0;
          end
        end

        // Only the final word is outstanding here; its acceptance ends the drain.
        FLUSH: begin
          if (handshake_d && out_last_q) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b1;
            if (clear_en_q) begin
              state_q <= CLEAR;
              clear_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        CLEAR: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accum_drain.sv
// Directed bench for accum_drain: a memory model of accumCol, a word-queue reference model,
// and a negedge compare process checking the output stream and side-band pulses.
module tb_accum_drain;

  logic       clock;
  logic       reset;
  logic       io_start;
  logic [4:0] io_count;
  logic       io_clear_en;
  logic       io_busy;
  logic       io_done;

  accum_drain_if #(.DATA_W(8), .ADDR_W(4)) ab ();

  accum_drain #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .io_start    (io_start),
    .io_count    (io_count),
    .io_clear_en (io_clear_en),
    .io_busy     (io_busy),
    .io_done     (io_done),
    .bus         (ab)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // accumCol model: combinational read, synchronous fill/clear.
  logic [7:0] mem [16];
  logic       fill_req;
  assign ab.io_acc_rd_data = mem[ab.io_acc_rd_addr];

  always @(posedge clock) begin
    if (fill_req) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'(i + 1);
    end else if (ab.io_acc_clear) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'd0;
    end
  end

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;
  int start_cyc = 0;
  bit mon_en  = 1'b0;

  int exp_q[$];
  int rd_cnt, rd_exp, acc_cnt, last_cnt, last_rel, clear_cnt, clear_rel;
  int done_cnt, done_rel, first_valid_rel, first_data, last_data, busy_low_rel;

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int mem_sum();
    int s = 0;
    for (int i = 0; i < 16; i++) s += int'(mem[i]);
    return s;
  endfunction

  task automatic clr_stats();
    rd_cnt = 0; rd_exp = 0; acc_cnt = 0; last_cnt = 0; last_rel = -1;
    clear_cnt = 0; clear_rel = -1; done_cnt = 0; done_rel = -1;
    first_valid_rel = -1; first_data = -1; last_data = -1; busy_low_rel = -1;
  endtask

  task automatic load_model(input int n);
    int eff;
    eff = (n > 16) ? 16 : n;
    exp_q.delete();
    for (int i = 0; i < eff; i++) exp_q.push_back(int'(mem[i]));
  endtask

  // Compare process: outputs sampled mid-cycle, handshake happens at the following rising edge.
  always @(negedge clock) begin
    if (reset && mon_en) begin
      int rel;
      rel = cyc - start_cyc;
      if (ab.io_out_valid) begin
        if (first_valid_rel < 0) first_valid_rel = rel;
        if (first_data < 0) first_data = int'(ab.io_out_data);
        if (exp_q.size() == 0) begin
          chk("extra_word", 1, 0);
        end else begin
          chk("out_data", int'(ab.io_out_data), exp_q[0]);
          chk("out_last", int'(ab.io_out_last), int'(exp_q.size() == 1));
          if (ab.io_out_ready) begin
            void'(exp_q.pop_front());
            acc_cnt++;
            last_data = int'(ab.io_out_data);
          end
        end
        if (ab.io_out_last) begin
          last_cnt++;
          last_rel = rel;
        end
      end
      if (ab.io_acc_rd_en) begin
        rd_cnt++;
        chk("rd_addr", int'(ab.io_acc_rd_addr), rd_exp);
        rd_exp++;
        chk("rd_en_on_load", int'(!ab.io_out_valid || ab.io_out_ready), 1);
        chk("rd_en_busy", int'(io_busy), 1);
      end
      if (ab.io_acc_rd_en && ab.io_acc_clear) chk("rd_clear_excl", 1, 0);
      if (ab.io_acc_clear) begin
        clear_cnt++;
        clear_rel = rel;
      end
      if (io_done) begin
        done_cnt++;
        done_rel = rel;
      end
      if (!io_busy && done_cnt > 0 && busy_low_rel < 0) busy_low_rel = rel;
    end
  end

  task automatic fill_mem();
    @(posedge clock); #1 fill_req = 1'b1;
    @(posedge clock); #1 fill_req = 1'b0;
  endtask

  // mode 0: ready always high; 1: ready 1,0,0 repeating; 2: ready high plus a restart pulse mid-drain.
  task automatic run_drain(input int n, input bit clr, input int mode);
    bit fin;
    fin = 1'b0;
    load_model(n);
    clr_stats();
    @(posedge clock); #1;
    start_cyc = cyc;
    io_start = 1'b1;
    io_count = 5'(n);
    io_clear_en = clr;
    ab.io_out_ready = 1'b1;
    mon_en = 1'b1;
    for (int r = 1; r < 400; r++) begin
      @(posedge clock); #1;
      io_start = (mode == 2) && (r == 4);
      if (r == 1) begin
        io_count = 5'd3;
        io_clear_en = ~clr;
      end
      ab.io_out_ready = (mode == 1) ? ((r % 3) == 0) : 1'b1;
      if (done_cnt > 0 && r >= done_rel + 2) begin
        fin = 1'b1;
        break;
      end
    end
    io_start = 1'b0;
    ab.io_out_ready = 1'b1;
    mon_en = 1'b0;
    chk("drain_finished", int'(fin), 1);
    chk("words_left", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b0;
    io_start = 1'b0;
    io_count = 5'd0;
    io_clear_en = 1'b0;
    ab.io_out_ready = 1'b0;
    fill_req = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy",  int'(io_busy), 0);
    chk("rst_done",  int'(io_done), 0);
    chk("rst_valid", int'(ab.io_out_valid), 0);
    chk("rst_last",  int'(ab.io_out_last), 0);
    chk("rst_data",  int'(ab.io_out_data), 0);
    chk("rst_clear", int'(ab.io_acc_clear), 0);
    chk("rst_rd_en", int'(ab.io_acc_rd_en), 0);
    reset = 1'b1;
    fill_mem();
    chk("fill_sum", mem_sum(), 136);

    // 1: full drain with clear, ready high
    run_drain(16, 1'b1, 0);
    chk("t1_first_valid_cyc", first_valid_rel, 2);
    chk("t1_first_data", first_data, 1);
    chk("t1_last_data", last_data, 16);
    chk("t1_last_cyc", last_rel, 17);
    chk("t1_last_cnt", last_cnt, 1);
    chk("t1_words", acc_cnt, 16);
    chk("t1_clear_cyc", clear_rel, 18);
    chk("t1_clear_cnt", clear_cnt, 1);
    chk("t1_done_cyc", done_rel, 18);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_busy_low_cyc", busy_low_rel, 19);
    chk("t1_mem_cleared", mem_sum(), 0);

    // 2: four words under back-pressure, no clear
    fill_mem();
    run_drain(4, 1'b0, 1);
    chk("t2_rd_pulses", rd_cnt, 4);
    chk("t2_words", acc_cnt, 4);
    chk("t2_first_data", first_data, 1);
    chk("t2_last_data", last_data, 4);
    chk("t2_clear_cnt", clear_cnt, 0);
    chk("t2_done_cnt", done_cnt, 1);

    // 3: empty drain, no clear
    run_drain(0, 1'b0, 0);
    chk("t3_rd_pulses", rd_cnt, 0);
    chk("t3_valid_seen", first_valid_rel, -1);
    chk("t3_clear_cnt", clear_cnt, 0);
    chk("t3_done_cyc", done_rel, 1);
    chk("t3_done_cnt", done_cnt, 1);

    // 4: oversize count clamps to the column depth
    run_drain(20, 1'b0, 0);
    chk("t4_rd_pulses", rd_cnt, 16);
    chk("t4_words", acc_cnt, 16);
    chk("t4_last_cnt", last_cnt, 1);
    chk("t4_last_data", last_data, 16);
    chk("t4_mem_kept", mem_sum(), 136);

    // 5: second start while busy is ignored
    run_drain(8, 1'b0, 2);
    chk("t5_rd_pulses", rd_cnt, 8);
    chk("t5_words", acc_cnt, 8);
    chk("t5_done_cnt", done_cnt, 1);

    // 6: reset while word 5 waits on a stalled output
    load_model(16);
    clr_stats();
    @(posedge clock); #1;
    start_cyc = cyc;
    io_start = 1'b1;
    io_count = 5'd16;
    io_clear_en = 1'b1;
    ab.io_out_ready = 1'b1;
    mon_en = 1'b1;
    for (int r = 1; r <= 6; r++) begin
      @(posedge clock); #1;
      io_start = 1'b0;
      ab.io_out_ready = (r < 6);
    end
    @(negedge clock);
    chk("t6_pending_valid", int'(ab.io_out_valid), 1);
    chk("t6_pending_data", int'(ab.io_out_data), 5);
    chk("t6_words_before", acc_cnt, 4);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_valid", int'(ab.io_out_valid), 0);
    chk("t6_rst_data",  int'(ab.io_out_data), 0);
    chk("t6_rst_last",  int'(ab.io_out_last), 0);
    chk("t6_rst_busy",  int'(io_busy), 0);
    chk("t6_rst_done",  int'(io_done), 0);
    chk("t6_rst_clear", int'(ab.io_acc_clear), 0);
    chk("t6_rst_rd_en", int'(ab.io_acc_rd_en), 0);
    mon_en = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    chk("t6_no_clear", clear_cnt, 0);
    chk("t6_mem_kept", mem_sum(), 136);
    run_drain(16, 1'b0, 0);
    chk("t6_redrain_first", first_data, 1);
    chk("t6_redrain_words", acc_cnt, 16);
    chk("t6_redrain_rd", rd_cnt, 16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
